uart_irq_ctrl: RTL



---
 rtl/uart_irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/uart_irq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_irq_pkg.sv
// Shared definitions for the UART status interrupt controller.
// Contains the source indices, the ID width and the controller state type.
package uart_irq_pkg;

   localparam int NSRC     = 7;
   localparam int IDW      = 3;

   localparam int SRC_FE   = 0;
   localparam int SRC_CRCE = 1;
   localparam int SRC_ORE  = 2;
   localparam int SRC_NF   = 3;
   localparam int SRC_TXI  = 4;
   localparam int SRC_TBNF = 5;
   localparam int SRC_DR   = 6;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      HOLD
   } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req.
// valid is high when any request bit is set.
module irq_prio_enc #(
   parameter int NSRC = uart_irq_pkg::NSRC
) (
   input  logic [NSRC-1:0]              req,
   output logic [uart_irq_pkg::IDW-1:0] id,
   output logic                         valid
);
   import uart_irq_pkg::*;

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      id    = '0;
      valid = |req;
      // Scan from the top down so that the lowest index is the one left in id.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) id = IDW'(i);
      end
   end

endmodule

// File: rtl/uart_irq_ctrl.sv
// Interrupt controller for the UART status register: edge-latched pending events,
// enable mask, fixed priority and a request/ack handshake with post-ack holdoff.
module uart_irq_ctrl #(
   parameter int NSRC    = uart_irq_pkg::NSRC,
   parameter int HOLDOFF = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NSRC-1:0]              status,
   input  logic                         mask_we,
   input  logic [NSRC-1:0]              mask_wdata,
   input  logic                         ack,
   output logic                         irq,
   output logic [uart_irq_pkg::IDW-1:0] irq_id,
   output logic [NSRC-1:0]              pending,
   output logic [NSRC-1:0]              lost
);
   import uart_irq_pkg::*;

   localparam logic [3:0] HOLDOFF_L = 4'(HOLDOFF);

   state_e           state_q, state_d;
   logic [NSRC-1:0]  status_q, status_d;
   logic [NSRC-1:0]  mask_q, mask_d;
   logic [NSRC-1:0]  pending_q, pending_d;
   logic [NSRC-1:0]  lost_q, lost_d;
   logic             irq_q, irq_d;
   logic [IDW-1:0]   irq_id_q, irq_id_d;
   logic [3:0]       cnt_q, cnt_d;

   logic [NSRC-1:0]  rise;
   logic [NSRC-1:0]  req;
   logic [NSRC-1:0]  clr;
   logic             service;
   logic [IDW-1:0]   enc_id;
   logic             enc_valid;

   irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
      .req   (req),
      .id    (enc_id),
      .valid (enc_valid)
   );

   // Edge detect, mask and the pending/lost bookkeeping.
   always_comb begin
      status_d  = status;
      rise      = status & ~status_q;
      mask_d    = mask_we ? mask_wdata : mask_q;
      req       = pending_q & mask_q;
      service   = (state_q == ASSERT) && ack;
      clr       = service ? (NSRC'(1) << irq_id_q) : '0;
      // A new edge overrides a same-cycle clear, so set wins.
      pending_d = (pending_q & ~clr) | rise;
      lost_d    = (lost_q & ~clr) | (rise & pending_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enc_valid) state_d = ASSERT;
         ASSERT:  if (ack)       state_d = HOLD;
         HOLD:    if (cnt_q <= 4'd1) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The ID is latched only on entry to ASSERT and held everywhere else.
   always_comb begin
      irq_d    = (state_d == ASSERT);
      irq_id_d = ((state_q == IDLE) && enc_valid) ? enc_id : irq_id_q;
      cnt_d    = cnt_q;
      if (service) begin
         cnt_d = HOLDOFF_L;
      end else if ((state_q == HOLD) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         status_q  <= '1;
         mask_q    <= '0;
         pending_q <= '0;
         lost_q    <= '0;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
         cnt_q     <= cnt_d;
      end
   end

   assign irq     = irq_q;
   assign irq_id  = irq_id_q;
   assign pending = pending_q;
   assign lost    = lost_q;

endmodule
